// File: rtl/usb_tx_bit_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : usb_tx_bit_ctrl_if
// Description : Handshake and line bundle between the TX packet FIFO side,
//               the USB full-speed bit-level transmitter and the line drivers.
//   tx_start       : start a packet (only acted on while the transmitter idles)
//   tx_data[7:0]   : packet byte
//   tx_data_valid  : tx_data / tx_last are valid
//   tx_last        : presented byte is the last byte of the packet
//   tx_data_ready  : byte taken this cycle when tx_data_valid is high
//   dplus_out      : D+ line level
//   dminus_out     : D- line level
//   tx_busy        : transmitter is not idle
//   tx_done        : one-cycle pulse when EOP completes
//   tx_err         : one-cycle pulse on byte underrun
// Revision    : 1.0 - initial release
// ============================================================================
interface usb_tx_bit_ctrl_if;
    logic       tx_start;
    logic [7:0] tx_data;
    logic       tx_data_valid;
    logic       tx_last;
    logic       tx_data_ready;
    logic       dplus_out;
    logic       dminus_out;
    logic       tx_busy;
    logic       tx_done;
    logic       tx_err;

    // Packet source / line observer side
    modport master (
        output tx_start, tx_data, tx_data_valid, tx_last,
        input  tx_data_ready, dplus_out, dminus_out, tx_busy, tx_done, tx_err
    );

    // Transmitter side
    modport slave (
        input  tx_start, tx_data, tx_data_valid, tx_last,
        output tx_data_ready, dplus_out, dminus_out, tx_busy, tx_done, tx_err
    );
endinterface
`default_nettype wire

// File: rtl/usb_tx_bit_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : usb_tx_bit_ctrl
// Description : USB full-speed transmit bit-level controller. Emits SYNC,
//               serializes packet bytes LSB-first at one bit per
//               CLKS_PER_BIT clocks, inserts a stuff 0 after six consecutive
//               ones, NRZI-encodes onto D+/D- and closes with SE0,SE0,J.
// Ports       : clk   - system clock
//               n_rst - asynchronous active-low reset
//               bus   - usb_tx_bit_ctrl_if.slave (handshake + line outputs)
// Parameters  : CLKS_PER_BIT - clocks per bit period (>= 2)
// Revision    : 1.0 - initial release
// ============================================================================
module usb_tx_bit_ctrl #(
    parameter int CLKS_PER_BIT = 8
) (
    input  wire logic        clk,
    input  wire logic        n_rst,
    usb_tx_bit_ctrl_if.slave bus
);

    localparam int                    C_TIMER_W = $clog2(CLKS_PER_BIT);
    localparam logic [C_TIMER_W-1:0]  C_BND     = C_TIMER_W'(CLKS_PER_BIT - 1);
    localparam logic [C_TIMER_W-1:0]  C_PRE_BND = C_TIMER_W'(CLKS_PER_BIT - 2);
    localparam logic [C_TIMER_W-1:0]  C_T_ONE   = C_TIMER_W'(1);
    localparam logic [7:0]            C_SYNC    = 8'h80;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_SYNC    = 3'd1,
        ST_DATA    = 3'd2,
        ST_STUFF   = 3'd3,
        ST_EOP_SE0 = 3'd4,
        ST_EOP_J   = 3'd5
    } state_t;

    state_t               state_q;
    logic [C_TIMER_W-1:0] timer_q;
    logic [7:0]           shift_q;
    logic [2:0]           bitcnt_q;   // bit index in byte; also SE0 period count
    logic [2:0]           ones_q;
    logic                 last_q;     // byte in shift_q is the last of the packet
    logic                 level_q;    // NRZI level: 1 = J, 0 = K
    logic                 dp_q;
    logic                 dm_q;
    logic                 done_q;
    logic                 err_q;

    logic                 w_bnd;
    logic                 w_byte_end;
    logic                 w_need_stuff;
    logic                 w_fetch;

    // Returns {next level, D+, D-} after sending one NRZI bit.
    function automatic logic [2:0] f_line(input logic lvl, input logic b);
        logic nl;
        nl = b ? lvl : ~lvl;
        return {nl, nl, ~nl};
    endfunction

    always_comb begin
        w_bnd        = (timer_q == C_BND);
        w_byte_end   = (bitcnt_q == 3'd7);
        // Current bit is a 1 that makes the sixth consecutive one.
        w_need_stuff = ((state_q == ST_SYNC) || (state_q == ST_DATA))
                       && shift_q[0] && (ones_q == 3'd5);
        // A new byte is needed when the next bit is bit 0 of a fresh byte.
        // A pending stuff bit defers the fetch to the end of STUFF.
        w_fetch      = w_bnd && w_byte_end && !last_q &&
                       ((state_q == ST_SYNC) ||
                        ((state_q == ST_DATA) && !w_need_stuff) ||
                        (state_q == ST_STUFF));
    end

    assign bus.tx_data_ready = w_fetch;
    assign bus.tx_busy       = (state_q != ST_IDLE);
    assign bus.dplus_out     = dp_q;
    assign bus.dminus_out    = dm_q;
    assign bus.tx_done       = done_q;
    assign bus.tx_err        = err_q;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q  <= ST_IDLE;
            timer_q  <= '0;
            shift_q  <= 8'h00;
            bitcnt_q <= 3'd0;
            ones_q   <= 3'd0;
            last_q   <= 1'b0;
            level_q  <= 1'b1;
            dp_q     <= 1'b1;
            dm_q     <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;

            if (state_q == ST_IDLE) begin
                timer_q <= '0;
            end else if (w_bnd) begin
                timer_q <= '0;
            end else begin
                timer_q <= timer_q + C_T_ONE;
            end

            case (state_q)
                ST_IDLE: begin
                    ones_q   <= 3'd0;
                    bitcnt_q <= 3'd0;
                    last_q   <= 1'b0;
                    level_q  <= 1'b1;
                    dp_q     <= 1'b1;
                    dm_q     <= 1'b0;
                    if (bus.tx_start) begin
                        state_q <= ST_SYNC;
                        shift_q <= C_SYNC;
                        {level_q, dp_q, dm_q} <= f_line(1'b1, C_SYNC[0]);
                    end
                end

                ST_SYNC, ST_DATA, ST_STUFF: begin
                    if (w_bnd) begin
                        if (w_need_stuff) begin
                            // Shift register holds; the stuff 0 goes out next.
                            state_q <= ST_STUFF;
                            ones_q  <= ones_q + 3'd1;
                            {level_q, dp_q, dm_q} <= f_line(level_q, 1'b0);
                        end else begin
                            if (state_q == ST_STUFF) begin
                                ones_q <= 3'd0;
                            end else if (shift_q[0]) begin
                                ones_q <= ones_q + 3'd1;
                            end else begin
                                ones_q <= 3'd0;
                            end

                            if (!w_byte_end) begin
                                shift_q  <= shift_q >> 1;
                                bitcnt_q <= bitcnt_q + 3'd1;
                                state_q  <= (state_q == ST_SYNC) ? ST_SYNC : ST_DATA;
                                {level_q, dp_q, dm_q} <= f_line(level_q, shift_q[1]);
                            end else if (last_q) begin
                                state_q  <= ST_EOP_SE0;
                                bitcnt_q <= 3'd0;
                                dp_q     <= 1'b0;
                                dm_q     <= 1'b0;
                            end else if (bus.tx_data_valid) begin
                                shift_q  <= bus.tx_data;
                                last_q   <= bus.tx_last;
                                bitcnt_q <= 3'd0;
                                state_q  <= ST_DATA;
                                {level_q, dp_q, dm_q} <= f_line(level_q, bus.tx_data[0]);
                            end else begin
                                // Underrun: truncate the packet with an EOP.
                                err_q    <= 1'b1;
                                state_q  <= ST_EOP_SE0;
                                bitcnt_q <= 3'd0;
                                dp_q     <= 1'b0;
                                dm_q     <= 1'b0;
                            end
                        end
                    end
                end

                ST_EOP_SE0: begin
                    ones_q <= 3'd0;
                    if (w_bnd) begin
                        if (bitcnt_q == 3'd1) begin
                            state_q  <= ST_EOP_J;
                            bitcnt_q <= 3'd0;
                            level_q  <= 1'b1;
                            dp_q     <= 1'b1;
                            dm_q     <= 1'b0;
                        end else begin
                            bitcnt_q <= bitcnt_q + 3'd1;
                        end
                    end
                end

                ST_EOP_J: begin
                    // Registered so that done is visible on the final boundary.
                    if (timer_q == C_PRE_BND) begin
                        done_q <= 1'b1;
                    end
                    if (w_bnd) begin
                        state_q <= ST_IDLE;
                    end
                end

                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_usb_tx_bit_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_usb_tx_bit_ctrl
// Description : Self-checking bench for usb_tx_bit_ctrl with two instances
//               (CLKS_PER_BIT = 8 and 2). Expected line symbols are built from
//               a bit list (SYNC + data with stuffing) NRZI-encoded and
//               followed by SE0,SE0,J.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_usb_tx_bit_ctrl;

    logic clk = 1'b0;
    logic n_rst;
    always #5 clk = ~clk;

    usb_tx_bit_ctrl_if if8();
    usb_tx_bit_ctrl_if if2();

    usb_tx_bit_ctrl #(.CLKS_PER_BIT(8)) u_dut8 (.clk(clk), .n_rst(n_rst), .bus(if8));
    usb_tx_bit_ctrl #(.CLKS_PER_BIT(2)) u_dut2 (.clk(clk), .n_rst(n_rst), .bus(if2));

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] pkt_q[$];
    int         under;        // byte index at which valid is withheld, -1 none
    bit         m_bits[$];
    int         m_ones;
    logic [1:0] m_sym[$];

    localparam logic [1:0] C_J   = 2'b10;
    localparam logic [1:0] C_K   = 2'b01;
    localparam logic [1:0] C_SE0 = 2'b00;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [1:0] get_line(input bit sel);
        return sel ? {if2.dplus_out, if2.dminus_out} : {if8.dplus_out, if8.dminus_out};
    endfunction
    function automatic logic get_busy(input bit sel);
        return sel ? if2.tx_busy : if8.tx_busy;
    endfunction
    function automatic logic get_ready(input bit sel);
        return sel ? if2.tx_data_ready : if8.tx_data_ready;
    endfunction
    function automatic logic get_done(input bit sel);
        return sel ? if2.tx_done : if8.tx_done;
    endfunction
    function automatic logic get_err(input bit sel);
        return sel ? if2.tx_err : if8.tx_err;
    endfunction

    task automatic drive(input bit sel, input logic s, input logic v,
                         input logic [7:0] d, input logic l);
        if (sel) begin
            if2.tx_start = s; if2.tx_data_valid = v; if2.tx_data = d; if2.tx_last = l;
        end else begin
            if8.tx_start = s; if8.tx_data_valid = v; if8.tx_data = d; if8.tx_last = l;
        end
    endtask

    // Reference: bit list with stuffing after every sixth consecutive one.
    task automatic push_bit(input bit b);
        m_bits.push_back(b);
        m_ones = b ? m_ones + 1 : 0;
        if (m_ones == 6) begin
            m_bits.push_back(1'b0);
            m_ones = 0;
        end
    endtask

    task automatic run_packet(input bit sel, input string name);
        int         cpb, nbytes, nb, total, idx;
        int         rdy_cnt, done_cnt, err_cnt, done_c, err_c, exp_fetch;
        logic       lvl;
        logic [1:0] exp_line;
        logic [7:0] cur;

        cpb = sel ? 2 : 8;
        m_bits.delete();
        m_sym.delete();
        m_ones = 0;
        for (int i = 0; i < 8; i++) push_bit(i == 7);
        nbytes = (under >= 0) ? under : pkt_q.size();
        for (int j = 0; j < nbytes; j++) begin
            cur = pkt_q[j];
            for (int i = 0; i < 8; i++) push_bit(cur[i]);
        end
        nb  = m_bits.size();
        lvl = 1'b1;
        foreach (m_bits[i]) begin
            if (!m_bits[i]) lvl = ~lvl;
            for (int k = 0; k < cpb; k++) m_sym.push_back(lvl ? C_J : C_K);
        end
        for (int k = 0; k < 2 * cpb; k++) m_sym.push_back(C_SE0);
        for (int k = 0; k < cpb; k++) m_sym.push_back(C_J);
        total     = m_sym.size();
        exp_fetch = (under >= 0) ? under + 1 : pkt_q.size();

        idx = 0; rdy_cnt = 0; done_cnt = 0; err_cnt = 0; done_c = -1; err_c = -1;
        @(negedge clk);
        drive(sel, 1'b1, 1'b0, 8'h00, 1'b0);
        @(negedge clk);
        for (int c = 1; c <= total + 1; c++) begin
            exp_line = (c <= total) ? m_sym[c-1] : C_J;
            check($sformatf("%s line c=%0d", name, c), get_line(sel), exp_line);
            check($sformatf("%s busy c=%0d", name, c), get_busy(sel), (c <= total));
            if (get_done(sel)) begin done_cnt++; done_c = c; end
            if (get_err(sel))  begin err_cnt++;  err_c  = c; end
            if (get_ready(sel)) begin
                rdy_cnt++;
                check($sformatf("%s ready_bnd c=%0d", name, c), c % cpb, 0);
                if (idx < pkt_q.size() && idx != under) begin
                    drive(sel, 1'b0, 1'b1, pkt_q[idx], idx == pkt_q.size() - 1);
                    idx++;
                end else begin
                    drive(sel, 1'b0, 1'b0, 8'($urandom), 1'($urandom));
                end
            end else begin
                drive(sel, 1'b0, 1'($urandom), 8'($urandom), 1'($urandom));
            end
            // Stray starts while busy must be ignored.
            if (c < total && ($urandom % 16) == 0) begin
                if (sel) if2.tx_start = 1'b1; else if8.tx_start = 1'b1;
            end
            @(negedge clk);
        end
        drive(sel, 1'b0, 1'b0, 8'h00, 1'b0);
        check({name, " ready_count"}, rdy_cnt, exp_fetch);
        check({name, " done_count"}, done_cnt, 1);
        check({name, " done_cycle"}, done_c, total);
        check({name, " err_count"}, err_cnt, (under >= 0) ? 1 : 0);
        if (under >= 0) check({name, " err_cycle"}, err_c, nb * cpb + 1);
    endtask

    initial begin
        int idx;
        drive(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
        drive(1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
        n_rst = 1'b0;
        repeat (3) @(negedge clk);
        for (int s = 0; s < 2; s++) begin
            check($sformatf("rst line%0d", s),  get_line(s[0]),  C_J);
            check($sformatf("rst busy%0d", s),  get_busy(s[0]),  1'b0);
            check($sformatf("rst ready%0d", s), get_ready(s[0]), 1'b0);
            check($sformatf("rst done%0d", s),  get_done(s[0]),  1'b0);
            check($sformatf("rst err%0d", s),   get_err(s[0]),   1'b0);
        end
        n_rst = 1'b1;
        repeat (2) @(negedge clk);

        // Directed cases
        under = -1;
        pkt_q = '{8'h00};        run_packet(1'b0, "b00");
        pkt_q = '{8'hFF};        run_packet(1'b0, "bFF");
        pkt_q = '{8'h3F};        run_packet(1'b0, "b3F");
        pkt_q = '{8'h7E, 8'h7E}; run_packet(1'b0, "b7E7E");
        pkt_q = '{8'hA5, 8'h5A, 8'h11}; under = 1; run_packet(1'b0, "under");
        under = -1;
        pkt_q = '{8'hFF, 8'hFF}; run_packet(1'b1, "c2FFFF");
        pkt_q = '{8'hFF, 8'hFF}; run_packet(1'b0, "c8FFFF");

        // Reset in the middle of DATA
        pkt_q = '{8'hA5, 8'h3C};
        idx = 0;
        @(negedge clk);
        drive(1'b0, 1'b1, 1'b0, 8'h00, 1'b0);
        for (int c = 1; c <= 100; c++) begin
            @(negedge clk);
            if (if8.tx_data_ready && idx < pkt_q.size()) begin
                drive(1'b0, 1'b0, 1'b1, pkt_q[idx], idx == 1);
                idx++;
            end else begin
                drive(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
            end
        end
        check("midrst busy_before", if8.tx_busy, 1'b1);
        n_rst = 1'b0;
        #1;
        check("midrst line",  get_line(1'b0),  C_J);
        check("midrst busy",  get_busy(1'b0),  1'b0);
        check("midrst ready", get_ready(1'b0), 1'b0);
        @(negedge clk);
        drive(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
        n_rst = 1'b1;
        @(negedge clk);
        pkt_q = '{8'h00}; under = -1;
        run_packet(1'b0, "after_rst");

        // Randomized packets on both instances
        for (int t = 0; t < 40; t++) begin
            int n;
            pkt_q.delete();
            n = $urandom_range(1, 4);
            for (int j = 0; j < n; j++) begin
                case ($urandom % 4)
                    0:       pkt_q.push_back(8'hFF);
                    1:       pkt_q.push_back(8'hFE);
                    default: pkt_q.push_back(8'($urandom));
                endcase
            end
            under = (($urandom % 5) == 0) ? int'($urandom_range(0, n - 1)) : -1;
            run_packet(t[0], $sformatf("rnd%0d", t));
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
